// File: rtl/divider_ctrl_pkg.sv
// divider_ctrl_pkg: state encodings and width defaults shared by the restoring divider files.
package divider_ctrl_pkg;
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_LOAD = 2'd1;
    localparam logic [1:0] DIV_ITER = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;
    localparam int DIV_WIDTH = 4;
    localparam int DIV_CNT_W = 4;
endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring-division step, shifting {a,q} left and trial-subtracting m.
module divider_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] q_nxt
);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] trial;
    logic             ge;
    // a < m holds between steps, so a kept trial always fits back in WIDTH bits
    always_comb begin
        sh    = {a, q[WIDTH-1]};
        ge    = sh >= {1'b0, m};
        trial = sh[WIDTH-1:0] - m;
        a_nxt = ge ? trial : sh[WIDTH-1:0];
        q_nxt = {q[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/divider_ctrl.sv
// divider_ctrl: restoring-divider FSM and datapath driving an external iteration counter.
// Optional macro DIV_ZERO_DETECT_EN adds the dbz output and a short path for divisor 0.
module divider_ctrl
    import divider_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [DIV_CNT_W-1:0] count,
    output logic                 cnt_inc,
    output logic                 cnt_clr,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
`ifdef DIV_ZERO_DETECT_EN
    output logic                 dbz,
`endif
    output logic [WIDTH-1:0]     remainder
);
    logic [1:0]       state, nxt;
    logic [WIDTH-1:0] a, q, m, a_nxt, q_nxt;
    logic             last, zero;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .a     (a),
        .q     (q),
        .m     (m),
        .a_nxt (a_nxt),
        .q_nxt (q_nxt)
    );

    assign last = count == DIV_CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_DETECT_EN
    assign zero = m == '0;
`else
    assign zero = 1'b0;
`endif

    always_comb
        nxt = state == DIV_IDLE ? (start ? DIV_LOAD : DIV_IDLE) :
              state == DIV_LOAD ? (zero ? DIV_DONE : DIV_ITER) :
              state == DIV_ITER ? (last ? DIV_DONE : DIV_ITER) : DIV_IDLE;

    assign busy    = state == DIV_LOAD || state == DIV_ITER;
    assign done    = state == DIV_DONE;
    assign cnt_inc = state == DIV_ITER;
    assign cnt_clr = state == DIV_LOAD;

    // operands are latched on acceptance so later input changes cannot leak into the loop
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= DIV_IDLE;
            a         <= '0;
            q         <= '0;
            m         <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dbz       <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (state == DIV_IDLE && start) begin
                a <= '0;
                q <= dividend;
                m <= divisor;
`ifdef DIV_ZERO_DETECT_EN
                dbz <= 1'b0;
`endif
            end
            if (state == DIV_ITER) begin
                a <= a_nxt;
                q <= q_nxt;
            end
            if (state == DIV_ITER && last) begin
                quotient  <= q_nxt;
                remainder <= a_nxt;
            end
`ifdef DIV_ZERO_DETECT_EN
            if (state == DIV_LOAD && zero) begin
                quotient  <= '1;
                remainder <= q;
                dbz       <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: table, corner-case and random checks of divider_ctrl with a modelled counter.
module tb_divider_ctrl;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif
    logic       clk = 1'b0, clr = 1'b1, start = 1'b0;
    logic [3:0] dividend = '0, divisor = '0, count;
    logic       cnt_inc, cnt_clr, busy, done;
    logic [3:0] quotient, remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic       dbz;
`endif
    int vectors = 0, miscompares = 0;

    typedef struct {
        logic [3:0] a, b, q, r;
    } vec_t;

    divider_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .count     (count),
        .cnt_inc   (cnt_inc),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
`ifdef DIV_ZERO_DETECT_EN
        .dbz       (dbz),
`endif
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    // iteration counter that sits beside the controller in the divider top
    always @(posedge clk or posedge clr)
        if (clr) count <= '0;
        else if (cnt_clr) count <= '0;
        else if (cnt_inc) count <= count + 4'd1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // starts at a negedge with the DUT idle; mode 1 re-pulses start mid-op, mode 2 pulses clr mid-op
    task automatic op(input logic [3:0] a, b, eq, er, input int mode);
        int n = 0, incs = 0, lat, bad = 0;
        bit seen = 0;
        lat = (ZD && b == 0) ? 2 : 6;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (cnt_inc) incs++;
            if (cnt_inc && cnt_clr) bad++;
            if ((cnt_inc || cnt_clr) && !busy) bad++;
            if (mode == 1 && n == 3) begin
                start = 1'b1; dividend = 4'd2; divisor = 4'd1;
            end
            if (mode == 1 && n == 4) start = 1'b0;
            if (mode == 2 && n == 3) clr = 1'b1;
            if (mode == 2 && n == 4) begin
                chk("clr_outputs", int'({busy, done, cnt_inc, cnt_clr, quotient, remainder}), 0);
                clr = 1'b0;
            end
            seen = done;
        end
        chk("done_seen", int'(seen), int'(mode != 2));
        chk("ctl_flags", bad, 0);
        if (seen) begin
            chk("latency", n, lat);
            chk("quotient", int'(quotient), int'(eq));
            chk("remainder", int'(remainder), int'(er));
            chk("inc_cycles", incs, lat == 2 ? 0 : 4);
`ifdef DIV_ZERO_DETECT_EN
            chk("dbz", int'(dbz), int'(b == 0));
`endif
            @(negedge clk);
            chk("done_pulse", int'(done), 0);
            chk("hold_q", int'(quotient), int'(eq));
        end
    endtask

    initial begin
        vec_t tbl[7];
        int times[$];
        logic [3:0] ra, rb;
        tbl = '{'{13, 4, 3, 1}, '{15, 1, 15, 0}, '{7, 9, 0, 7}, '{9, 0, 15, 9},
                '{0, 5, 0, 0}, '{15, 15, 1, 0}, '{1, 15, 0, 1}};
        @(negedge clk);
        chk("reset_outputs", int'({busy, done, cnt_inc, cnt_clr, quotient, remainder}), 0);
        clr = 1'b0;
        @(negedge clk);
        chk("idle_hold", int'({busy, done, cnt_inc, cnt_clr}), 0);
        for (int i = 0; i < 7; i++) op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, 0);
        op(13, 4, 3, 1, 1);
        op(13, 4, 3, 1, 2);
        op(6, 3, 2, 0, 0);
        // start held high: back-to-back operations
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                times.push_back(i);
                chk("b2b_q", int'(quotient), 4);
                chk("b2b_r", int'(remainder), 2);
            end
        end
        start = 1'b0;
        chk("b2b_count", times.size(), 4);
        for (int i = 1; i < times.size(); i++) chk("b2b_gap", times[i] - times[i-1], 7);
        repeat (10) @(negedge clk);
        chk("b2b_idle", int'(busy), 0);
        // random operands against plain-arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(15, 0));
            rb = (i % 8 == 0) ? 4'd0 : 4'($urandom_range(15, 0));
            op(ra, rb, rb == 0 ? 4'hF : ra / rb, rb == 0 ? ra : ra % rb, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
